// File: rtl/mdr_pkg.sv
// mdr_pkg: shared operation/state encodings and iteration-count helper for the MDR iterative core
package mdr_pkg;

   typedef enum logic [1:0] {OP_MUL, OP_DIV, OP_SQRT, OP_RSV} mdr_op_e;

   typedef enum logic [2:0] {IDLE, LOAD_X, LOAD_Y, CALC, FIX} state_e;

   // square root retires two radicand bits per step, mul/div one bit per step
   localparam int BITS_PER_STEP_MD = 1;
   localparam int BITS_PER_STEP_SQ = 2;

   function automatic int iter_count(mdr_op_e op, int dw);
      return op == OP_SQRT ? dw / BITS_PER_STEP_SQ : dw / BITS_PER_STEP_MD;
   endfunction

endpackage

// File: rtl/mdr_iter_datapath.sv
// mdr_iter_datapath: shared shift/accumulate registers, one mul/div/sqrt step per enabled cycle
// Ports: clk; rst (async, active low); init loads a into lo and clears hi/rt; step advances one
//   iteration of op; b is the multiplicand/divisor (held by the caller); hi/lo/rt expose the state:
//   mul -> {hi,lo} product; div -> lo quotient, hi remainder; sqrt -> rt root, hi remainder.
module mdr_iter_datapath
   import mdr_pkg::*;
#(
   parameter int DW = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            init,
   input  logic            step,
   input  mdr_op_e         op,
   input  logic [DW-1:0]   a,
   input  logic [DW-1:0]   b,
   output logic [DW-1:0]   hi,
   output logic [DW-1:0]   lo,
   output logic [DW/2-1:0] rt
);
   logic [DW:0]   mul_sum, div_sh, sq_r;
   logic [DW-1:0] div_dif, sq_t, sq_dif;
   logic          div_ge, sq_ge;

   // differences are taken modulo 2^DW: they are only used when the true value is known to fit
   always_comb begin
      mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, b} : '0);
      div_sh  = {hi, lo[DW-1]};
      div_ge  = div_sh >= {1'b0, b};
      div_dif = div_sh[DW-1:0] - b;
      sq_r    = {hi[DW-2:0], lo[DW-1:DW-2]};
      sq_t    = DW'({rt, 2'b01});
      sq_ge   = sq_r >= {1'b0, sq_t};
      sq_dif  = sq_r[DW-1:0] - sq_t;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hi <= '0;
         lo <= '0;
         rt <= '0;
      end else if (init) begin
         hi <= '0;
         lo <= a;
         rt <= '0;
      end else if (step) begin
         case (op)
            OP_MUL: {hi, lo} <= {mul_sum, lo[DW-1:1]};
            OP_DIV: begin
               hi <= div_ge ? div_dif : div_sh[DW-1:0];
               lo <= {lo[DW-2:0], div_ge};
            end
            OP_SQRT: begin
               hi <= sq_ge ? sq_dif : sq_r[DW-1:0];
               lo <= {lo[DW-3:0], 2'b00};
               rt <= {rt[DW/2-2:0], sq_ge};
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/mdr_iter_core.sv
// mdr_iter_core: iterative multiply/divide/square-root engine with serially loaded operands
// Ports: clk; rst (async, active low); start+op begin an operation from IDLE; load+data capture
//   X then Y (Y only for mul/div); load_x/load_y/busy report progress; ready pulses for one cycle
//   when result/remainder/error are valid; error is sticky until the next accepted start.
// Build option: define MDR_SIGNED_EN for two's-complement operands (sign fixed up in FIX).
module mdr_iter_core
   import mdr_pkg::*;
#(
   parameter  int DW    = 16,
   localparam int CNT_W = $clog2(DW) + 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            load,
   input  logic [DW-1:0]   data,
   input  logic [1:0]      op,
   output logic            load_x,
   output logic            load_y,
   output logic            busy,
   output logic            ready,
   output logic            error,
   output logic [2*DW-1:0] result,
   output logic [DW-1:0]   remainder
);
   state_e           state, nxt;
   mdr_op_e          op_q;
   logic [DW-1:0]    x, y, xm, ym, dm, hi, lo, rem_m, rem_n;
   logic [DW/2-1:0]  rt;
   logic [2*DW-1:0]  mag_res, res_n;
   logic [CNT_W-1:0] cnt;
   logic             init, dz, err_n;

   // operand registers keep the raw bus value; the datapath always sees magnitudes
`ifdef MDR_SIGNED_EN
   assign xm = x[DW-1] ? -x : x;
   assign ym = y[DW-1] ? -y : y;
   assign dm = data[DW-1] ? -data : data;
`else
   assign xm = x;
   assign ym = y;
   assign dm = data;
`endif

   // sqrt starts straight from the bus on its only load; mul/div start once Y arrives
   mdr_iter_datapath #(.DW(DW)) u_dp (
      .clk  (clk),
      .rst  (rst),
      .init (init),
      .step (state == CALC),
      .op   (op_q),
      .a    (op_q == OP_SQRT ? dm : xm),
      .b    (ym),
      .hi   (hi),
      .lo   (lo),
      .rt   (rt)
   );

   assign busy   = state != IDLE;
   assign load_x = state == LOAD_X;
   assign load_y = state == LOAD_Y;

   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= IDLE;
      else      state <= nxt;

   // a zero divisor skips CALC entirely so ready follows the Y load by two cycles
   always_comb begin
      nxt  = state;
      init = 1'b0;
      case (state)
         IDLE:   nxt = (start && op != OP_RSV) ? LOAD_X : IDLE;
         LOAD_X: if (load) begin
            nxt  = op_q == OP_SQRT ? CALC : LOAD_Y;
            init = op_q == OP_SQRT;
         end
         LOAD_Y: if (load) begin
            nxt  = (op_q == OP_DIV && data == '0) ? FIX : CALC;
            init = 1'b1;
         end
         CALC:   nxt = cnt == CNT_W'(1) ? FIX : CALC;
         FIX:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_comb begin
      dz      = op_q == OP_DIV && y == '0;
      err_n   = dz;
      mag_res = op_q == OP_MUL ? {hi, lo} :
                op_q == OP_DIV ? {{DW{1'b0}}, lo} : {{(2*DW-DW/2){1'b0}}, rt};
      rem_m   = op_q == OP_MUL ? '0 : hi;
`ifdef MDR_SIGNED_EN
      res_n   = (op_q != OP_SQRT && (x[DW-1] ^ y[DW-1])) ? -mag_res : mag_res;
      rem_n   = x[DW-1] ? -rem_m : rem_m;
      if (op_q == OP_SQRT && x[DW-1]) begin
         err_n = 1'b1;
         res_n = '0;
         rem_n = '0;
      end
`else
      res_n   = mag_res;
      rem_n   = rem_m;
`endif
      if (dz) begin
         res_n = '1;
         rem_n = x;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_q      <= OP_MUL;
         x         <= '0;
         y         <= '0;
         cnt       <= '0;
         ready     <= 1'b0;
         error     <= 1'b0;
         result    <= '0;
         remainder <= '0;
      end else begin
         ready <= 1'b0;
         if (state == IDLE && start) begin
            op_q  <= mdr_op_e'(op);
            error <= op == OP_RSV;
            ready <= op == OP_RSV;
            if (op == OP_RSV) begin
               result    <= '0;
               remainder <= '0;
            end
         end
         if (state == LOAD_X && load) x <= data;
         if (state == LOAD_Y && load) y <= data;
         cnt <= init ? CNT_W'(iter_count(op_q, DW)) : state == CALC ? cnt - 1'b1 : cnt;
         if (state == FIX) begin
            result    <= res_n;
            remainder <= rem_n;
            error     <= err_n;
            ready     <= 1'b1;
         end
      end
   end

endmodule
